fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch front-end between the I-cache port (address/read/resp/rdata) and the datapath's decode stage. It owns the fetch PC and issues one I-cache read at a time. Returned words go into a small FIFO as {pc, inst} pairs for decode to consume under stall control. Taken-branch/jump redirects from the datapath flush the FIFO and kill any in-flight response.

Parameters:
RESET_PC, 32'h00000060, first fetch address after reset
BUF_DEPTH, 2, FIFO entries for fetched {pc, inst} pairs (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  decode cannot accept; holds current head entry
redirect  input  1  pulse; fetch must restart at redirect_pc
redirect_pc  input  32  redirect target
imem_address  output  32  I-cache read address
imem_read  output  1  I-cache read request
imem_resp  input  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  input  32  instruction word
inst  output  32  head-of-FIFO instruction
inst_pc  output  32  PC of inst
inst_valid  output  1  FIFO non-empty; entry consumed when inst_valid && !stall

Behaviour:
- Registers: fetch_pc (next PC to request), req_addr (drives imem_address), FIFO plus count, and state in {IDLE, REQ, DROP}.
- Reset (async, takes effect immediately with no clock edge): state=IDLE, fetch_pc=req_addr=RESET_PC, count=0, so imem_read=0, imem_address=RESET_PC, inst_valid=0. inst and inst_pc read 0 while empty.
- imem_read=1 exactly in REQ and DROP. imem_address=req_addr, stable from request start until imem_resp. At most one request outstanding.
- IDLE -> REQ when count_next < BUF_DEPTH; on that edge req_addr<=fetch_pc.
- REQ with imem_resp and no redirect:
  - push {req_addr, imem_rdata}; fetch_pc<=req_addr+4 (mod 2^32: 0xFFFFFFFC -> 0x0).
  - If count_next < BUF_DEPTH: stay REQ with req_addr<=req_addr+4, giving back-to-back requests with no idle cycle.
  - Otherwise go to IDLE.
- REQ without resp: hold.
- DROP: hold imem_read/req_addr until imem_resp; discard the word; then go to REQ with req_addr<=fetch_pc (FIFO is empty, so there is space).
- Redirect (priority over stall and push):
  - FIFO cleared (count_next=0); inst_valid=0 the following cycle.
  - fetch_pc<={redirect_pc[31:2],2'b00}; low bits are forced to 0.
  - From IDLE, or from REQ/DROP when imem_resp is asserted the same cycle: the response is discarded; next state is REQ with req_addr=aligned target.
  - From REQ/DROP with no resp: next state is DROP. The old request completes unmodified and its data is dropped. A second redirect while in DROP updates fetch_pc again.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pop happens only when inst_valid && !stall.
  - Push never occurs when full. This is guaranteed by the issue rule, and verification asserts it.
  - Head output is registered FIFO storage, not a bypass of imem_rdata.
- Latency: imem_resp in cycle N with an empty FIFO gives inst_valid=1 in cycle N+1. Steady-state throughput is one instruction per memory response.
- stall does not affect imem_read directly; it only prevents pops.

Test Plan:
- Reset released, 1-cycle memory, stall=0, mem[0x60+4k]=k+1 -> imem_address 0x60,0x64,0x68; inst_pc/inst sequence (0x60,1),(0x64,2),(0x68,3), no gaps beyond memory latency.
- stall=1 for 6 cycles after first fetch -> FIFO fills at 2 entries, imem_read=0, inst stays (0x60,1); on release, order is 0x60,0x64,0x68 with no loss or duplication.
- Memory resp delayed 3 cycles; redirect to 0x200 one cycle after request for 0x68 -> imem_address stays 0x68 until resp, that word never appears; next request 0x200; next valid inst_pc=0x200.
- redirect to 0x300 in the same cycle as imem_resp for 0x64 -> word dropped, FIFO empty next cycle, next imem_address=0x300.
- redirect_pc=0x203 -> fetch at 0x200; redirect_pc=0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000.
- rst asserted mid-REQ between edges -> imem_read=0, inst_valid=0, imem_address=0x60 immediately; after release, fetch restarts at 0x60.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: owns the fetch PC, keeps one I-cache read in flight,
// and queues returned {pc, inst} pairs in a small FIFO for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000060,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_reg;
    logic [31:0]        fetch_pc_reg;
    logic [31:0]        req_addr_reg;
    logic               imem_read_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    logic [31:0]        pc_mem   [BUF_DEPTH];
    logic [31:0]        inst_mem [BUF_DEPTH];

    logic               push;
    logic               pop;
    logic               has_space;
    logic [31:0]        redirect_target;
    logic [31:0]        req_addr_inc;

    // Targets are word aligned; the low two bits of redirect_pc are ignored.
    assign redirect_target = redirect_pc & ~32'h3;
    assign req_addr_inc    = req_addr_reg + 32'd4;

    assign inst_valid = (count_reg != '0);
    // A redirect kills both the arriving word and any pending pop.
    assign push = (state_reg == REQ) && imem_resp && !redirect;
    assign pop  = inst_valid && !stall && !redirect;

    always_comb begin
        count_next = count_reg;
        if (redirect) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Issue only when the word we would fetch is guaranteed a free slot.
    assign has_space = (count_next < DEPTH_C);

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= req_addr_reg;
            inst_mem[wr_ptr_reg] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= RESET_PC;
            req_addr_reg  <= RESET_PC;
            imem_read_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_reg  <= redirect_target;
                        req_addr_reg  <= redirect_target;
                        state_reg     <= REQ;
                        imem_read_reg <= 1'b1;
                    end else if (has_space) begin
                        req_addr_reg  <= fetch_pc_reg;
                        state_reg     <= REQ;
                        imem_read_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_target;
                        if (imem_resp) begin
                            req_addr_reg <= redirect_target;
                        end else begin
                            // Old read must finish untouched; its data is thrown away.
                            state_reg <= DROP;
                        end
                    end else if (imem_resp) begin
                        fetch_pc_reg <= req_addr_inc;
                        if (has_space) begin
                            req_addr_reg <= req_addr_inc;
                        end else begin
                            state_reg     <= IDLE;
                            imem_read_reg <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (redirect) begin
                        fetch_pc_reg <= redirect_target;
                        if (imem_resp) begin
                            req_addr_reg <= redirect_target;
                            state_reg    <= REQ;
                        end
                    end else if (imem_resp) begin
                        req_addr_reg <= fetch_pc_reg;
                        state_reg    <= REQ;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    imem_read_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_address = req_addr_reg;
    assign imem_read    = imem_read_reg;
    assign inst         = inst_valid ? inst_mem[rd_ptr_reg] : 32'd0;
    assign inst_pc      = inst_valid ? pc_mem[rd_ptr_reg]   : 32'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wait_cnt = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // mem[0x60 + 4k] = k + 1
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) - 32'd23;
    endfunction

    // Memory answers after `lat` wait cycles of a held request.
    always @(posedge clk) begin
        if (imem_read && !imem_resp) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end
    assign imem_resp  = imem_read && (wait_cnt == lat);
    assign imem_rdata = mem_word(imem_address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        lat = 0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_read", imem_read, 0);
        chk("rst_addr", imem_address, 32'h60);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        tick();
        rst = 1'b0;
        chk("idle_read", imem_read, 0);

        // Streaming with single-cycle memory
        tick();
        chk("s_read", imem_read, 1);
        chk("s_addr0", imem_address, 32'h60);
        chk("s_valid0", inst_valid, 0);
        tick();
        chk("s_valid1", inst_valid, 1);
        chk("s_pc1", inst_pc, 32'h60);
        chk("s_inst1", inst, 32'd1);
        chk("s_addr1", imem_address, 32'h64);
        tick();
        chk("s_pc2", inst_pc, 32'h64);
        chk("s_inst2", inst, 32'd2);
        chk("s_addr2", imem_address, 32'h68);
        tick();
        chk("s_pc3", inst_pc, 32'h68);
        chk("s_inst3", inst, 32'd3);
        chk("s_addr3", imem_address, 32'h6c);

        // Stall fills the FIFO and stops issue
        do_reset();
        tick();
        tick();
        chk("st_pc0", inst_pc, 32'h60);
        stall = 1'b1;
        tick();
        chk("st_full_read", imem_read, 0);
        chk("st_full_pc", inst_pc, 32'h60);
        chk("st_full_inst", inst, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_hold_read", imem_read, 0);
            chk("st_hold_pc", inst_pc, 32'h60);
        end
        stall = 1'b0;
        tick();
        chk("st_rel_pc", inst_pc, 32'h64);
        chk("st_rel_inst", inst, 32'd2);
        chk("st_rel_read", imem_read, 1);
        chk("st_rel_addr", imem_address, 32'h68);
        tick();
        chk("st_next_pc", inst_pc, 32'h68);
        chk("st_next_inst", inst, 32'd3);

        // Redirect while a slow request is outstanding
        lat = 3;
        do_reset();
        tick();
        chk("d_addr0", imem_address, 32'h60);
        chk("d_resp0", imem_resp, 0);
        repeat (4) tick();
        chk("d_pc0", inst_pc, 32'h60);
        chk("d_addr1", imem_address, 32'h64);
        repeat (4) tick();
        chk("d_pc1", inst_pc, 32'h64);
        chk("d_addr2", imem_address, 32'h68);
        tick();
        chk("d_empty", inst_valid, 0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("d_drop_read", imem_read, 1);
        chk("d_drop_addr", imem_address, 32'h68);
        chk("d_drop_valid", inst_valid, 0);
        tick();
        chk("d_drop_addr2", imem_address, 32'h68);
        chk("d_drop_resp", imem_resp, 1);
        tick();
        chk("d_new_addr", imem_address, 32'h200);
        chk("d_new_valid", inst_valid, 0);
        for (int i = 0; i < 10 && !inst_valid; i++) tick();
        chk("d_wait", inst_valid, 1);
        chk("d_new_pc", inst_pc, 32'h200);
        chk("d_new_inst", inst, 32'd105);

        // Redirect coincident with a response
        lat = 0;
        do_reset();
        tick();
        tick();
        chk("c_resp", imem_resp, 1);
        chk("c_addr", imem_address, 32'h64);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        chk("c_flush", inst_valid, 0);
        chk("c_addr_new", imem_address, 32'h300);
        chk("c_read", imem_read, 1);
        tick();
        chk("c_pc", inst_pc, 32'h300);
        chk("c_inst", inst, 32'd169);

        // Misaligned target and address wrap
        redirect = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        chk("a_valid", inst_valid, 0);
        chk("a_addr", imem_address, 32'h200);
        tick();
        chk("a_pc", inst_pc, 32'h200);
        chk("a_inst", inst, 32'd105);
        redirect = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect = 1'b0;
        chk("w_addr", imem_address, 32'hFFFFFFFC);
        chk("w_valid", inst_valid, 0);
        tick();
        chk("w_pc0", inst_pc, 32'hFFFFFFFC);
        chk("w_inst0", inst, 32'h3FFFFFE8);
        chk("w_addr_wrap", imem_address, 32'h0);
        tick();
        chk("w_pc1", inst_pc, 32'h0);
        chk("w_inst1", inst, 32'hFFFFFFE9);

        // Asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        chk("ar_read", imem_read, 0);
        chk("ar_valid", inst_valid, 0);
        chk("ar_addr", imem_address, 32'h60);
        chk("ar_pc", inst_pc, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_restart_addr", imem_address, 32'h60);
        chk("ar_restart_read", imem_read, 1);
        tick();
        chk("ar_restart_pc", inst_pc, 32'h60);
        chk("ar_restart_inst", inst, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
